// File: rtl/tlc_phase_sequencer.sv
// Traffic-light sequencer: GREEN -> YELLOW -> ALLRED over NUM_PHASES conflicting phases with latched demand.
// Optional emergency preemption is built only when TLC_PREEMPT_EN is defined.
module tlc_phase_sequencer #(
  parameter int NUM_PHASES = 4,
  parameter int TIMER_W    = 8,
  parameter int GREEN_OFF  = 16,
  parameter int GREEN_PEAK = 32,
  parameter int YELLOW_T   = 4,
  parameter int ALLRED_T   = 2,
  localparam int PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_PHASES-1:0]   sensor,
  input  logic                    peak,
`ifdef TLC_PREEMPT_EN
  input  logic                    preempt,
  input  logic [PW-1:0]           preempt_phase,
`endif
  output logic [2*NUM_PHASES-1:0] lights,
  output logic [PW-1:0]           active_phase,
  output logic [1:0]              phase_state
);

  if (NUM_PHASES < 2 || NUM_PHASES > 8) begin : g_bad_np
    $error("tlc_phase_sequencer: NUM_PHASES must be 2..8");
  end
  if (GREEN_OFF < 1 || GREEN_OFF > (2**TIMER_W) - 1) begin : g_bad_off
    $error("tlc_phase_sequencer: GREEN_OFF out of timer range");
  end
  if (GREEN_PEAK < 1 || GREEN_PEAK > (2**TIMER_W) - 1) begin : g_bad_peak
    $error("tlc_phase_sequencer: GREEN_PEAK out of timer range");
  end
  if (YELLOW_T < 1 || YELLOW_T > 2**TIMER_W || ALLRED_T < 1 || ALLRED_T > 2**TIMER_W) begin : g_bad_clr
    $error("tlc_phase_sequencer: YELLOW_T/ALLRED_T out of timer range");
  end

  typedef enum logic [1:0] {
    S_GREEN  = 2'd0,
    S_YELLOW = 2'd1,
    S_ALLRED = 2'd2
  } state_t;

  localparam logic [TIMER_W-1:0] L_OFF  = TIMER_W'(GREEN_OFF);
  localparam logic [TIMER_W-1:0] L_PEAK = TIMER_W'(GREEN_PEAK);
  localparam logic [TIMER_W-1:0] L_YEL  = TIMER_W'(YELLOW_T - 1);
  localparam logic [TIMER_W-1:0] L_AR   = TIMER_W'(ALLRED_T - 1);
  localparam logic [2*NUM_PHASES-1:0] L_ALL_RED   = {NUM_PHASES{2'd2}};
  localparam logic [2*NUM_PHASES-1:0] L_RST_LIGHT = {{(NUM_PHASES-1){2'd2}}, 2'd0};

  state_t                  r_state, w_state_n;
  logic [TIMER_W-1:0]      r_timer, w_timer_n;
  logic [TIMER_W-1:0]      r_glen, w_glen, w_glen_n;
  logic                    r_fresh;
  logic [PW-1:0]           r_active, w_active_n, w_next_phase, w_target, w_cand;
  logic                    w_found, w_enter_green;
  logic [NUM_PHASES-1:0]   r_demand, w_demand_n, w_busy, w_clr;
  logic [2*NUM_PHASES-1:0] r_lights, w_lights_n;
  logic                    w_pre_cut, w_pre_hold;

  // The green after reset release has no ALLRED entry edge, so peak is taken live on its first cycle.
  assign w_glen = r_fresh ? (peak ? L_PEAK : L_OFF) : r_glen;

  // Next served phase: first phase after the active one with demand, phase 0 always qualifies.
  always_comb begin
    w_next_phase = '0;
    w_cand       = '0;
    w_found      = 1'b0;
    for (int k = 1; k <= NUM_PHASES; k++) begin
      w_cand = PW'((int'(r_active) + k) % NUM_PHASES);
      if (!w_found && (w_cand == '0 || r_demand[w_cand])) begin
        w_next_phase = w_cand;
        w_found      = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

`ifdef TLC_PREEMPT_EN
  logic          r_pre_pend;
  logic [PW-1:0] r_pre_tgt;

  assign w_pre_cut  = preempt && (r_state == S_GREEN) && (r_active != preempt_phase);
  assign w_pre_hold = preempt && (r_state == S_GREEN) && (r_active == preempt_phase);
  assign w_target   = r_pre_pend ? r_pre_tgt : w_next_phase;

  // A preempt target stays pending through YELLOW/ALLRED even if the request drops meanwhile.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre_pend <= 1'b0;
      r_pre_tgt  <= '0;
    end else begin
      if (w_enter_green) begin
        r_pre_pend <= preempt && (preempt_phase != w_target);
      end else if (preempt && !w_pre_hold) begin
        r_pre_pend <= 1'b1;
      end else begin
        r_pre_pend <= r_pre_pend;
      end
      r_pre_tgt <= preempt ? preempt_phase : r_pre_tgt;
    end
  end
`else
  assign w_pre_cut  = 1'b0;
  assign w_pre_hold = 1'b0;
  assign w_target   = w_next_phase;
`endif

  // Phase FSM: state, timer, active phase, green length latch and demand clear.
  always_comb begin
    w_state_n     = r_state;
    w_timer_n     = r_timer + TIMER_W'(1);
    w_active_n    = r_active;
    w_glen_n      = w_glen;
    w_enter_green = 1'b0;
    w_clr         = '0;
    case (r_state)
      S_GREEN: begin
        if (w_pre_cut) begin
          w_state_n = S_YELLOW;
          w_timer_n = '0;
        end else if (w_pre_hold) begin
          w_timer_n = '0;
        end else if (r_timer == w_glen - TIMER_W'(1)) begin
          if (r_active == '0 && r_demand[NUM_PHASES-1:1] == '0) begin
            w_timer_n = r_timer;
          end else begin
            w_state_n = S_YELLOW;
            w_timer_n = '0;
          end
        end else begin
          w_timer_n = r_timer + TIMER_W'(1);
        end
      end
      S_YELLOW: begin
        if (r_timer == L_YEL) begin
          w_state_n = S_ALLRED;
          w_timer_n = '0;
        end else begin
          w_timer_n = r_timer + TIMER_W'(1);
        end
      end
      S_ALLRED: begin
        if (r_timer == L_AR) begin
          w_state_n         = S_GREEN;
          w_timer_n         = '0;
          w_active_n        = w_target;
          w_glen_n          = peak ? L_PEAK : L_OFF;
          w_enter_green     = 1'b1;
          w_clr[w_target]   = 1'b1;
        end else begin
          w_timer_n = r_timer + TIMER_W'(1);
        end
      end
      default: begin
        w_state_n  = S_GREEN;
        w_timer_n  = '0;
        w_active_n = '0;
      end
    endcase
  end

  // Demand latch; the group currently owning green/yellow ignores its sensor, and clear wins over set.
  always_comb begin
    w_busy = '0;
    if (r_state != S_ALLRED) begin
      w_busy[r_active] = 1'b1;
    end else begin
      w_busy = '0;
    end
    w_demand_n = (r_demand | (sensor & ~w_busy)) & ~w_clr;
  end

  // Lamp codes derived from the next state so the registered lamps line up with the state register.
  always_comb begin
    w_lights_n = L_ALL_RED;
    case (w_state_n)
      S_GREEN:  w_lights_n[{w_active_n, 1'b0} +: 2] = 2'd0;
      S_YELLOW: w_lights_n[{w_active_n, 1'b0} +: 2] = 2'd1;
      S_ALLRED: w_lights_n = L_ALL_RED;
      default:  w_lights_n = L_ALL_RED;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_GREEN;
      r_timer  <= '0;
      r_active <= '0;
      r_demand <= '0;
      r_glen   <= L_OFF;
      r_fresh  <= 1'b1;
      r_lights <= L_RST_LIGHT;
    end else begin
      r_state  <= w_state_n;
      r_timer  <= w_timer_n;
      r_active <= w_active_n;
      r_demand <= w_demand_n;
      r_glen   <= w_glen_n;
      r_fresh  <= 1'b0;
      r_lights <= w_lights_n;
    end
  end

  assign lights       = r_lights;
  assign active_phase = r_active;
  assign phase_state  = r_state;

endmodule

// File: tb/tb_tlc_phase_sequencer.sv
// Self-checking bench for tlc_phase_sequencer (NP=4, G=16/32, Y=4, AR=2) against a segment-countdown model.
module tb_tlc_phase_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] sensor = 4'd0;
  logic       peak = 1'b0;
  logic [7:0] lights;
  logic [1:0] active_phase;
  logic [1:0] phase_state;
`ifdef TLC_PREEMPT_EN
  logic       preempt = 1'b0;
  logic [1:0] preempt_phase = 2'd0;
`endif

  int checks = 0;
  int failures = 0;

  tlc_phase_sequencer #(
    .NUM_PHASES(4), .TIMER_W(8), .GREEN_OFF(16), .GREEN_PEAK(32), .YELLOW_T(4), .ALLRED_T(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sensor(sensor),
    .peak(peak),
`ifdef TLC_PREEMPT_EN
    .preempt(preempt),
    .preempt_phase(preempt_phase),
`endif
    .lights(lights),
    .active_phase(active_phase),
    .phase_state(phase_state)
  );

  always #5 clk = ~clk;

  // Reference model: current segment (0=green,1=yellow,2=allred), owner phase, cycles left in segment.
  int       m_st, m_ph, m_left, m_len, m_tgt;
  bit [3:0] m_dem;
  bit       m_fresh, m_pend;

  function automatic int glen(input bit pk);
    return pk ? 32 : 16;
  endfunction

  task automatic model_reset();
    m_st = 0; m_ph = 0; m_len = 16; m_left = 16; m_dem = 4'd0;
    m_fresh = 1'b1; m_pend = 1'b0; m_tgt = 0;
  endtask

  function automatic logic [7:0] exp_lights();
    logic [7:0] v;
    v = 8'hAA;
    if (m_st != 2) v[2*m_ph +: 2] = 2'(m_st);
    return v;
  endfunction

  task automatic model_step(input bit [3:0] s, input bit pk, input bit pre, input int pph);
    bit [3:0] d;
    bit entered, hold_now, found;
    int nxt, j;
    d = m_dem; entered = 1'b0; nxt = 0; found = 1'b0;
    for (int i = 0; i < 4; i++)
      if (s[i] && !(m_st != 2 && m_ph == i)) d[i] = 1'b1;
    if (m_fresh) begin m_len = glen(pk); m_left = m_len; m_fresh = 1'b0; end
    hold_now = pre && m_st == 0 && m_ph == pph;
    case (m_st)
      0: begin
        if (pre && m_ph != pph) begin m_st = 1; m_left = 4; end
        else if (pre) m_left = m_len;
        else if (m_left > 1) m_left--;
        else if (!(m_ph == 0 && m_dem[3:1] == 3'd0)) begin m_st = 1; m_left = 4; end
      end
      1: if (m_left > 1) m_left--; else begin m_st = 2; m_left = 2; end
      default: begin
        if (m_left > 1) m_left--;
        else begin
          if (m_pend) nxt = m_tgt;
          else for (int k = 1; k <= 4; k++) begin
            j = (m_ph + k) % 4;
            if (!found && (j == 0 || m_dem[j])) begin nxt = j; found = 1'b1; end
          end
          m_st = 0; m_ph = nxt; m_len = glen(pk); m_left = m_len; d[nxt] = 1'b0; entered = 1'b1;
        end
      end
    endcase
    if (entered) m_pend = pre && (pph != nxt);
    else if (pre && !hold_now) m_pend = 1'b1;
    if (pre) m_tgt = pph;
    m_dem = d;
  endtask

  // Drive inputs for the coming edge, advance the model, then settle just after the edge.
  task automatic tick(input bit [3:0] s, input bit pk, input bit pre, input int pph);
    sensor = s; peak = pk;
`ifdef TLC_PREEMPT_EN
    preempt = pre; preempt_phase = 2'(pph);
`endif
    model_step(s, pk, pre, pph);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; sensor = 4'd0; peak = 1'b0;
`ifdef TLC_PREEMPT_EN
    preempt = 1'b0; preempt_phase = 2'd0;
`endif
    #2;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b0; #2;
    checks++; if (lights !== 8'hA8) begin failures++; $display("FAIL reset_lights got=%h want=a8", lights); end
    checks++; if (active_phase !== 2'd0) begin failures++; $display("FAIL reset_phase got=%0d want=0", active_phase); end
    checks++; if (phase_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", phase_state); end
    @(posedge clk); #1;
    reset = 1'b1; model_reset();
    for (int n = 1; n <= 100; n++) begin
      tick(4'd0, 1'b0, 1'b0, 0);
      checks++;
      if (lights !== 8'hA8 || phase_state !== 2'd0 || active_phase !== 2'd0) begin
        failures++; $display("FAIL rest_idle cyc=%0d got=%h/%0d/%0d want=a8/0/0", n, lights, active_phase, phase_state);
      end
    end
  endtask

  task automatic test_sensor_pulse();
    int es, ep;
    logic [7:0] xl;
    do_reset();
    for (int n = 1; n <= 60; n++) begin
      tick((n == 20) ? 4'b0100 : 4'b0000, 1'b0, 1'b0, 0);
      if (n <= 20) begin es = 0; ep = 0; end
      else if (n <= 24) begin es = 1; ep = 0; end
      else if (n <= 26) begin es = 2; ep = 0; end
      else if (n <= 42) begin es = 0; ep = 2; end
      else if (n <= 46) begin es = 1; ep = 2; end
      else if (n <= 48) begin es = 2; ep = 2; end
      else begin es = 0; ep = 0; end
      xl = 8'hAA;
      if (es != 2) xl[2*ep +: 2] = 2'(es);
      checks++;
      if (phase_state !== 2'(es) || lights !== xl) begin
        failures++; $display("FAIL pulse_timeline cyc=%0d got=%0d/%h want=%0d/%h", n, phase_state, lights, es, xl);
      end
    end
  endtask

  task automatic test_peak_toggle();
    int g0, g1;
    do_reset();
    g0 = (phase_state == 2'd0 && active_phase == 2'd0) ? 1 : 0;
    g1 = 0;
    for (int n = 1; n <= 80; n++) begin
      tick(4'b1110, n >= 5, 1'b0, 0);
      checks++;
      if (lights !== exp_lights() || active_phase !== 2'(m_ph) || phase_state !== 2'(m_st)) begin
        failures++; $display("FAIL peak_lockstep cyc=%0d got=%h/%0d/%0d want=%h/%0d/%0d", n, lights, active_phase, phase_state, exp_lights(), m_ph, m_st);
      end
      if (phase_state == 2'd0 && active_phase == 2'd0) g0++;
      if (phase_state == 2'd0 && active_phase == 2'd1) g1++;
    end
    checks++; if (g0 != 16) begin failures++; $display("FAIL peak_green0_len got=%0d want=16", g0); end
    checks++; if (g1 != 32) begin failures++; $display("FAIL peak_green1_len got=%0d want=32", g1); end
  endtask

  task automatic test_rotation();
    int order[$];
    int run;
    logic [1:0] prev;
    do_reset();
    run = 1; prev = 2'd0;
    for (int n = 1; n <= 170; n++) begin
      tick(4'b1110, 1'b1, 1'b0, 0);
      if (phase_state == 2'd0 && prev == 2'd2) order.push_back(int'(active_phase));
      if (phase_state == 2'd0) run++;
      if (phase_state == 2'd1 && prev == 2'd0) begin
        checks++;
        if (run != 32) begin failures++; $display("FAIL rot_green_len cyc=%0d got=%0d want=32", n, run); end
        run = 0;
      end
      prev = phase_state;
    end
    checks++;
    if (order.size() != 4) begin
      failures++; $display("FAIL rot_count got=%0d want=4", order.size());
    end else if (order[0] != 1 || order[1] != 2 || order[2] != 3 || order[3] != 0) begin
      failures++; $display("FAIL rot_order got=%0d,%0d,%0d,%0d want=1,2,3,0", order[0], order[1], order[2], order[3]);
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    do_reset();
    hit = 1'b0;
    for (int n = 1; n <= 200 && !hit; n++) begin
      tick((n <= 3) ? 4'b1110 : 4'b0000, 1'b0, 1'b0, 0);
      if (phase_state == 2'd1 && active_phase == 2'd1) hit = 1'b1;
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL midreset_reach got=timeout want=phase1_yellow"); end
    reset = 1'b0; #2;
    checks++;
    if (lights !== 8'hA8 || active_phase !== 2'd0 || phase_state !== 2'd0) begin
      failures++; $display("FAIL midreset_async got=%h/%0d/%0d want=a8/0/0", lights, active_phase, phase_state);
    end
    #2 reset = 1'b1; model_reset();
    for (int n = 1; n <= 60; n++) begin
      tick(4'd0, 1'b0, 1'b0, 0);
      checks++;
      if (lights !== 8'hA8 || phase_state !== 2'd0) begin
        failures++; $display("FAIL midreset_demand_clr cyc=%0d got=%h/%0d want=a8/0", n, lights, phase_state);
      end
    end
  endtask

  task automatic test_random();
    bit [3:0] s;
    bit pk, pre;
    int pph;
    pk = 1'b0; pre = 1'b0; pph = 0;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      s = 4'd0;
      if ($urandom_range(0, 11) == 0) s[$urandom_range(0, 3)] = 1'b1;
      if ($urandom_range(0, 49) == 0) pk = ~pk;
`ifdef TLC_PREEMPT_EN
      if ($urandom_range(0, 99) == 0) begin pre = ~pre; pph = int'($urandom_range(0, 3)); end
`endif
      if ($urandom_range(0, 399) == 0) begin reset = 1'b0; #2 reset = 1'b1; model_reset(); end
      tick(s, pk, pre, pph);
      checks++;
      if (lights !== exp_lights() || active_phase !== 2'(m_ph) || phase_state !== 2'(m_st)) begin
        failures++; $display("FAIL rand_lockstep cyc=%0d got=%h/%0d/%0d want=%h/%0d/%0d", n, lights, active_phase, phase_state, exp_lights(), m_ph, m_st);
      end
    end
  endtask

`ifdef TLC_PREEMPT_EN
  task automatic test_preempt();
    bit hit;
    do_reset();
    hit = 1'b0;
    for (int n = 1; n <= 100 && !hit; n++) begin
      tick(4'b1110, 1'b0, 1'b0, 0);
      if (phase_state == 2'd0 && active_phase == 2'd1) hit = 1'b1;
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL preempt_reach got=timeout want=phase1_green"); end
    for (int n = 1; n <= 100; n++) begin
      tick(4'b0000, 1'b0, n <= 40, 3);
      checks++;
      if (lights !== exp_lights() || active_phase !== 2'(m_ph) || phase_state !== 2'(m_st)) begin
        failures++; $display("FAIL preempt_lockstep cyc=%0d got=%h/%0d/%0d want=%h/%0d/%0d", n, lights, active_phase, phase_state, exp_lights(), m_ph, m_st);
      end
      if (n == 40) begin
        checks++;
        if (active_phase !== 2'd3 || phase_state !== 2'd0) begin
          failures++; $display("FAIL preempt_hold got=%0d/%0d want=3/0", active_phase, phase_state);
        end
      end
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_sensor_pulse();
    test_peak_toggle();
    test_rotation();
    test_reset_mid();
`ifdef TLC_PREEMPT_EN
    test_preempt();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
